// File: rtl/bcd2binary_if.sv
// Handshake bundle between a decimal-entry source and the BCD-to-binary converter.
//
// Parameters:
//    DIN_W    packed-BCD input width (multiple of 4)
//    DOUT_W   binary output width
//
// Signals:
//    en            start request from the source
//    bcd_din       packed BCD word, digit0 in [3:0]
//    busy          converter is working (SHIFT or DONE)
//    bin_dout      binary result, held until the next result
//    bin_dout_vld  one-cycle result strobe
//    digit_err     one-cycle invalid-digit strobe (BCD2BIN_CHECK_EN builds only)
//
// Modports: master = source side, slave = converter side.
// Macro: BCD2BIN_CHECK_EN adds digit_err.
interface bcd2binary_if #(
   parameter int DIN_W  = 24,
   parameter int DOUT_W = 20
);
   logic              en;
   logic [DIN_W-1:0]  bcd_din;
   logic              busy;
   logic [DOUT_W-1:0] bin_dout;
   logic              bin_dout_vld;
`ifdef BCD2BIN_CHECK_EN
   logic              digit_err;

   modport master (
      output en, bcd_din,
      input  busy, bin_dout, bin_dout_vld, digit_err
   );
   modport slave (
      input  en, bcd_din,
      output busy, bin_dout, bin_dout_vld, digit_err
   );
`else
   modport master (
      output en, bcd_din,
      input  busy, bin_dout, bin_dout_vld
   );
   modport slave (
      input  en, bcd_din,
      output busy, bin_dout, bin_dout_vld
   );
`endif
endinterface

// File: rtl/bcd2binary.sv
// Serial packed-BCD to binary converter (reverse double-dabble, one shift per clock).
// An en pulse in IDLE captures bcd_din; DOUT_W shifts later the result is registered
// and announced with a one-cycle bin_dout_vld pulse. en while busy is ignored.
//
// Parameters:
//    DIN_W    BCD input width, multiple of 4 (default 6 digits)
//    DOUT_W   binary width and shift count; 2^DOUT_W must exceed 10^(DIN_W/4)-1
//
// Ports:
//    clk     system clock, rising edge
//    rst_n   asynchronous reset, active-low
//    bus     bcd2binary_if.slave (en, bcd_din, busy, bin_dout, bin_dout_vld[, digit_err])
//
// Macro: BCD2BIN_CHECK_EN -- when defined, digits above 9 are flagged at capture and
//    the conversion returns 0 with a digit_err pulse alongside bin_dout_vld.
module bcd2binary #(
   parameter int DIN_W  = 24,
   parameter int DOUT_W = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   bcd2binary_if.slave bus
);

   localparam int CNT_W = $clog2(DOUT_W);
   localparam int NDIG  = DIN_W / 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOUT_W - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      SHIFT = 3'b010,
      DONE  = 3'b100
   } state_t;

   // After the right shift, any digit that was doubled past 7 gets 3 removed so the
   // next halving stays a valid decimal halving.
   function automatic logic [DIN_W-1:0] dabble_fix(input logic [DIN_W-1:0] v);
      logic [DIN_W-1:0] r;
      logic [3:0]       dig;
      r = v;
      for (int d = 0; d < NDIG; d++) begin
         dig = v[4*d +: 4];
         if (dig >= 4'd8) dig = dig - 4'd3;
         r[4*d +: 4] = dig;
      end
      return r;
   endfunction

`ifdef BCD2BIN_CHECK_EN
   function automatic logic has_bad_digit(input logic [DIN_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < NDIG; d++) begin
         if (v[4*d +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction
`endif

   state_t             state;
   logic [DIN_W-1:0]   bcd_r;
   logic [DOUT_W-1:0]  bin_r;
   logic [CNT_W-1:0]   shift_cnt;
   logic               busy_r;
   logic [DOUT_W-1:0]  dout_r;
   logic               vld_r;

   logic [DIN_W+DOUT_W-1:0] cat_sh;
   logic [DIN_W-1:0]        bcd_nx;
   logic [DOUT_W-1:0]       bin_nx;

   always_comb begin
      cat_sh = {bcd_r, bin_r} >> 1;
      bin_nx = cat_sh[DOUT_W-1:0];
      bcd_nx = dabble_fix(cat_sh[DIN_W+DOUT_W-1:DOUT_W]);
   end

`ifdef BCD2BIN_CHECK_EN
   logic err_flag;
   logic err_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bcd_r     <= '0;
         bin_r     <= '0;
         shift_cnt <= '0;
         busy_r    <= 1'b0;
         dout_r    <= '0;
         vld_r     <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
         err_flag  <= 1'b0;
         err_r     <= 1'b0;
`endif
      end else begin
         vld_r <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
         err_r <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (bus.en) begin
                  bcd_r     <= bus.bcd_din;
                  bin_r     <= '0;
                  shift_cnt <= '0;
                  busy_r    <= 1'b1;
                  state     <= SHIFT;
`ifdef BCD2BIN_CHECK_EN
                  err_flag  <= has_bad_digit(bus.bcd_din);
`endif
               end
            end
            SHIFT: begin
               bcd_r <= bcd_nx;
               bin_r <= bin_nx;
               if (shift_cnt == CNT_LAST) begin
                  shift_cnt <= '0;
                  state     <= DONE;
               end else begin
                  shift_cnt <= shift_cnt + 1'b1;
               end
            end
            DONE: begin
`ifdef BCD2BIN_CHECK_EN
               dout_r <= err_flag ? '0 : bin_r;
               err_r  <= err_flag;
`else
               dout_r <= bin_r;
`endif
               vld_r  <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = busy_r;
   assign bus.bin_dout     = dout_r;
   assign bus.bin_dout_vld = vld_r;
`ifdef BCD2BIN_CHECK_EN
   assign bus.digit_err    = err_r;
`endif

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: table-driven single conversions, then
// hand-written sequences for en held high, reset mid-shift, back-to-back sweep,
// and (with BCD2BIN_CHECK_EN) the invalid-digit path.
module tb_bcd2binary;
   localparam int DIN_W  = 24;
   localparam int DOUT_W = 20;
   localparam int LAT    = DOUT_W + 1;   // edges from accepting edge to vld
   localparam int BUDGET = 60;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bcd2binary_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

   bcd2binary #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic [DIN_W-1:0] bcd;
      int unsigned      exp;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [DIN_W-1:0] to_bcd(input int unsigned dec);
      logic [DIN_W-1:0] r;
      int unsigned      v;
      r = '0;
      v = dec;
      for (int d = 0; d < DIN_W/4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // One pulsed conversion. lat = edges from accepting edge to vld, busy_cnt = cycles busy seen.
   task automatic run_one(input logic [DIN_W-1:0] bcd, output int lat, output int busy_cnt);
      int n;
      @(negedge clk);
      bus.bcd_din = bcd;
      bus.en      = 1'b1;
      @(negedge clk);
      bus.en   = 1'b0;
      n        = 1;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.bin_dout_vld && n < BUDGET) begin
         @(negedge clk);
         n++;
         if (bus.busy) busy_cnt++;
      end
      lat = n - 1;
   endtask

   int lat, bcnt, nvld, gap;
   int unsigned exp_q [$];
   int unsigned dec, expv;

   initial begin
      vecs[0] = '{24'h000015, 15};
      vecs[1] = '{24'h999999, 999999};
      vecs[2] = '{24'h000000, 0};
      vecs[3] = '{24'h000001, 1};
      vecs[4] = '{24'h123456, 123456};
      vecs[5] = '{24'h100000, 100000};
      vecs[6] = '{24'h000009, 9};
      vecs[7] = '{24'h090909, 90909};
      vecs[8] = '{24'h888888, 888888};

      bus.en      = 1'b0;
      bus.bcd_din = '0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_dout", bus.bin_dout, 0);
      chk("reset_vld",  bus.bin_dout_vld, 0);
`ifdef BCD2BIN_CHECK_EN
      chk("reset_err",  bus.digit_err, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven single conversions
      for (int i = 0; i < 9; i++) begin
         run_one(vecs[i].bcd, lat, bcnt);
         chk($sformatf("vec%0d_vld", i), bus.bin_dout_vld, 1);
         chk($sformatf("vec%0d_dout", i), bus.bin_dout, vecs[i].exp);
         chk($sformatf("vec%0d_lat", i), lat, LAT);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, LAT);
         chk($sformatf("vec%0d_busy_at_vld", i), bus.busy, 0);
`ifdef BCD2BIN_CHECK_EN
         chk($sformatf("vec%0d_err", i), bus.digit_err, 0);
`endif
         @(negedge clk);
         chk($sformatf("vec%0d_vld_pulse", i), bus.bin_dout_vld, 0);
         repeat (3) @(negedge clk);
         chk($sformatf("vec%0d_dout_hold", i), bus.bin_dout, vecs[i].exp);
      end

      // en held high, bcd_din changed mid-run
      @(negedge clk);
      bus.bcd_din = 24'h000151;
      bus.en      = 1'b1;
      repeat (5) @(negedge clk);
      bus.bcd_din = 24'h000777;
      lat  = 5;
      while (!bus.bin_dout_vld && lat < BUDGET) begin
         @(negedge clk);
         lat++;
      end
      chk("hold_vld", bus.bin_dout_vld, 1);
      chk("hold_captured", bus.bin_dout, 151);
      chk("hold_lat", lat - 1, LAT);
      @(negedge clk);
      chk("hold_restart_busy", bus.busy, 1);
      chk("hold_vld_pulse", bus.bin_dout_vld, 0);
      gap  = 1;
      nvld = 0;
      while (gap < BUDGET) begin
         @(negedge clk);
         gap++;
         if (bus.bin_dout_vld) break;
      end
      bus.en = 1'b0;
      chk("hold_second_vld", bus.bin_dout_vld, 1);
      chk("hold_period", gap, DOUT_W + 2);
      chk("hold_second_dout", bus.bin_dout, 777);
      repeat (DOUT_W + 4) begin
         @(negedge clk);
         if (bus.bin_dout_vld) nvld++;
      end
      chk("hold_no_extra_vld", nvld, 0);
      chk("hold_idle_busy", bus.busy, 0);

      // reset in the middle of SHIFT
      @(negedge clk);
      bus.bcd_din = 24'h000151;
      bus.en      = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (9) @(negedge clk);
      chk("rst_mid_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_dout", bus.bin_dout, 0);
      chk("rst_mid_vld", bus.bin_dout_vld, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nvld  = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.bin_dout_vld) nvld++;
      end
      chk("rst_mid_no_vld", nvld, 0);
      chk("rst_mid_dout_held0", bus.bin_dout, 0);
      run_one(24'h000042, lat, bcnt);
      chk("rst_after_dout", bus.bin_dout, 42);
      chk("rst_after_lat", lat, LAT);

      // back-to-back random sweep, en held high
      @(negedge clk);
      dec = 0;
      bus.bcd_din = to_bcd(dec);
      exp_q.push_back(dec);
      bus.en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (!bus.bin_dout_vld && gap < BUDGET);
         expv = exp_q.pop_front();
         if (!bus.bin_dout_vld) begin
            chk($sformatf("sweep%0d_timeout", i), 0, 1);
            break;
         end
         if (bus.bin_dout != expv)
            chk($sformatf("sweep%0d_dout", i), bus.bin_dout, expv);
         else
            chk("sweep_dout", bus.bin_dout, expv);
         if (i == 198) dec = 999999;
         else dec = $urandom_range(0, 999999);
         bus.bcd_din = to_bcd(dec);
         exp_q.push_back(dec);
         if (i == 199) bus.en = 1'b0;
      end
      @(negedge clk);
      chk("sweep_idle_busy", bus.busy, 0);

`ifdef BCD2BIN_CHECK_EN
      run_one(24'h00001A, lat, bcnt);
      chk("err_vld", bus.bin_dout_vld, 1);
      chk("err_flag", bus.digit_err, 1);
      chk("err_dout", bus.bin_dout, 0);
      @(negedge clk);
      chk("err_pulse", bus.digit_err, 0);
      run_one(24'h000042, lat, bcnt);
      chk("err_clear_flag", bus.digit_err, 0);
      chk("err_clear_dout", bus.bin_dout, 42);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
